axi_lite_arbiter: RTL

Two-requester AXI4-Lite arbiter between the core's instruction fetch unit (IFU, read-only) and load/store unit (LSU, read/write) and the single `io_master` bus leaving the core. It serialises traffic: exactly one transaction (one read or one write) is outstanding downstream at a time. Requesters are served round-robin. All channels of the granted requester are routed to the downstream bus until its response handshake completes.

---
 rtl/axi_lite_arbiter_pkg.sv | 28 ++
 rtl/axi_lite_arbiter_rr2.sv | 35 +++
 rtl/axi_lite_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU AXI4-Lite arbiter.
package axi_lite_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Two-way round-robin choice: bit 0 = IFU, bit 1 = LSU.
  // last_grant = 1 means LSU was served last, so IFU wins a tie.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
    logic [1:0] gnt;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/axi_lite_arbiter_rr2.sv
// Two-way round-robin picker that remembers which requester was served last.
module arb_rr2
  import axi_lite_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last_grant_r;

  // One-hot grant, only offered while the arbiter is able to accept a new transaction
  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      gnt = rr_pick(req, last_grant_r);
    end else begin
      gnt = 2'b00;
    end
  end

  // Remember the winner of every grant; reset favours IFU on the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_r <= 1'b1;
    end else if (grant_en && (gnt != 2'b00)) begin
      last_grant_r <= gnt[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Serialising AXI4-Lite arbiter: IFU (read-only) and LSU (read/write) share io_master,
// one transaction outstanding at a time, round-robin between the two requesters.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read port
  input  logic                ifu_arvalid,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  output logic [1:0]          ifu_rresp,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                ifu_rready,
  // LSU read/write port
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic [1:0]          lsu_rresp,
  output logic [DATA_W-1:0]   lsu_rdata,
  input  logic                lsu_rready,
  input  logic                lsu_awvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  output logic                lsu_awready,
  input  logic                lsu_wvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_bresp,
  input  logic                lsu_bready,
  // Downstream bus
  output logic                io_master_awvalid,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  input  logic                io_master_awready,
  output logic                io_master_wvalid,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  input  logic                io_master_wready,
  input  logic                io_master_bvalid,
  input  logic [1:0]          io_master_bresp,
  output logic                io_master_bready,
  output logic                io_master_arvalid,
  output logic [ADDR_W-1:0]   io_master_araddr,
  input  logic                io_master_arready,
  input  logic                io_master_rvalid,
  input  logic [1:0]          io_master_rresp,
  input  logic [DATA_W-1:0]   io_master_rdata,
  output logic                io_master_rready
);

  arb_state_e state_r;
  logic       ar_done_r;
  logic       aw_done_r;
  logic       w_done_r;
  logic [1:0] req_s;
  logic [1:0] gnt_s;
  logic       lsu_wr_pend_s;

  assign lsu_wr_pend_s = lsu_awvalid & lsu_wvalid;
  assign req_s         = {lsu_wr_pend_s | lsu_arvalid, ifu_arvalid};

  arb_rr2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req_s),
    .grant_en (state_r == IDLE),
    .gnt      (gnt_s)
  );

  // Transaction sequencing: grant from IDLE, track per-channel completion, return on response
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      ar_done_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ar_done_r <= 1'b0;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          if (gnt_s[0]) begin
            state_r <= IFU_RD;
          end else if (gnt_s[1]) begin
            state_r <= lsu_wr_pend_s ? LSU_WR : LSU_RD;
          end else begin
            state_r <= IDLE;
          end
        end
        IFU_RD, LSU_RD: begin
          if (io_master_rvalid && io_master_rready) begin
            state_r   <= IDLE;
            ar_done_r <= 1'b0;
          end else begin
            state_r   <= state_r;
            ar_done_r <= ar_done_r | (io_master_arvalid & io_master_arready);
          end
        end
        LSU_WR: begin
          if (io_master_bvalid && io_master_bready) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
          end else begin
            state_r   <= state_r;
            aw_done_r <= aw_done_r | (io_master_awvalid & io_master_awready);
            w_done_r  <= w_done_r | (io_master_wvalid & io_master_wready);
          end
        end
        default: begin
          state_r   <= IDLE;
          ar_done_r <= 1'b0;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational routing of the granted requester's channels onto io_master
  always_comb begin
    ifu_arready       = 1'b0;
    ifu_rvalid        = 1'b0;
    ifu_rresp         = 2'b00;
    ifu_rdata         = {DATA_W{1'b0}};
    lsu_arready       = 1'b0;
    lsu_rvalid        = 1'b0;
    lsu_rresp         = 2'b00;
    lsu_rdata         = {DATA_W{1'b0}};
    lsu_awready       = 1'b0;
    lsu_wready        = 1'b0;
    lsu_bvalid        = 1'b0;
    lsu_bresp         = 2'b00;
    io_master_awvalid = 1'b0;
    io_master_awaddr  = {ADDR_W{1'b0}};
    io_master_wvalid  = 1'b0;
    io_master_wdata   = {DATA_W{1'b0}};
    io_master_wstrb   = {(DATA_W/8){1'b0}};
    io_master_bready  = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_araddr  = {ADDR_W{1'b0}};
    io_master_rready  = 1'b0;
    case (state_r)
      IFU_RD: begin
        io_master_arvalid = ifu_arvalid & ~ar_done_r;
        io_master_araddr  = ifu_araddr;
        ifu_arready       = io_master_arready & ~ar_done_r;
        ifu_rvalid        = io_master_rvalid;
        ifu_rresp         = io_master_rresp;
        ifu_rdata         = io_master_rdata;
        io_master_rready  = ifu_rready;
      end
      LSU_RD: begin
        io_master_arvalid = lsu_arvalid & ~ar_done_r;
        io_master_araddr  = lsu_araddr;
        lsu_arready       = io_master_arready & ~ar_done_r;
        lsu_rvalid        = io_master_rvalid;
        lsu_rresp         = io_master_rresp;
        lsu_rdata         = io_master_rdata;
        io_master_rready  = lsu_rready;
      end
      LSU_WR: begin
        io_master_awvalid = lsu_awvalid & ~aw_done_r;
        io_master_awaddr  = lsu_awaddr;
        lsu_awready       = io_master_awready & ~aw_done_r;
        io_master_wvalid  = lsu_wvalid & ~w_done_r;
        io_master_wdata   = lsu_wdata;
        io_master_wstrb   = lsu_wstrb;
        lsu_wready        = io_master_wready & ~w_done_r;
        // The response may only be taken once both address and data have been delivered
        lsu_bvalid        = io_master_bvalid & aw_done_r & w_done_r;
        lsu_bresp         = io_master_bresp;
        io_master_bready  = lsu_bready & aw_done_r & w_done_r;
      end
      default: begin
        ifu_arready = 1'b0;
      end
    endcase
  end

endmodule
